// File: rtl/limn2600_cache_if.sv
// limn2600_cache_if: one request/response bus, used twice by the cache, once
// toward the CPU (cache is slave) and once toward DRAM (cache is master).
//
// Handshake: the master raises req with stable we/addr/wdata and holds all of
// them until it samples rdy=1 on a rising edge. That edge completes the
// transfer, and rdata is valid alongside rdy. rdy is meaningless while req=0.
//
// Signals:
//   req    master->slave  request strobe, held until rdy
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  32-bit byte address
//   wdata  master->slave  write data
//   rdata  slave->master  read data, valid with rdy
//   rdy    slave->master  completion
interface limn2600_cache_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdy;

  modport master (output req, we, addr, wdata, input rdata, rdy);
  modport slave  (input req, we, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/limn2600_cache.sv
// limn2600_cache: direct-mapped, write-through, no-write-allocate cache with
// one-word lines between the limn2600 CPU and DRAM. Addresses with bit 31 set
// bypass the cache as uncached MMIO. Includes a one-line-per-cycle flush sweep
// and wrapping 32-bit read hit/miss counters. All outputs are registered.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   cpu         slave side of the CPU bus (rdy is a one-cycle completion pulse)
//   mem         master side of the DRAM bus
//   flush       one-cycle pulse: invalidate every line
//   flush_busy  high while a flush is pending or sweeping
//   hit_cnt     cached read hits
//   miss_cnt    cached read misses
//   dbg_state   current FSM state (IDLE=0, RD_MISS=1, WR_THRU=2, RESP=3, FLUSH=4)
module limn2600_cache #(
  parameter int IDX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  limn2600_cache_if.slave         cpu,
  limn2600_cache_if.master        mem,
  input  logic                    flush,
  output logic                    flush_busy,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [2:0]              dbg_state
);
  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef enum logic [2:0] {IDLE, RD_MISS, WR_THRU, RESP, FLUSH} state_t;

  state_t state, state_next;

  logic [31:0]         line_data  [LINES];
  logic [TAG_BITS-1:0] line_tag   [LINES];
  logic [LINES-1:0]    line_valid;

  logic                flush_pend, pend_next;
  logic [IDX_BITS-1:0] flush_idx;

  // Lookup of the incoming CPU request.
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic                req_cached, req_hit;

  // The refill target comes from the latched DRAM address, so no separate
  // copy of the request address is needed while waiting in RD_MISS.
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic                fill_cached;

  logic flush_go, accept;
  logic unused_bits;

  assign req_idx     = cpu.addr[2+IDX_BITS-1:2];
  assign req_tag     = cpu.addr[31:2+IDX_BITS];
  assign req_cached  = ~cpu.addr[31];
  assign req_hit     = req_cached & line_valid[req_idx] & (line_tag[req_idx] == req_tag);

  assign fill_idx    = mem.addr[2+IDX_BITS-1:2];
  assign fill_tag    = mem.addr[31:2+IDX_BITS];
  assign fill_cached = ~mem.addr[31];

  // A new or pending flush beats a CPU request in IDLE.
  assign flush_go    = flush | flush_pend;
  assign accept      = (state == IDLE) & ~flush_go & cpu.req;

  assign dbg_state   = state;
  assign unused_bits = ^{cpu.addr[1:0], mem.addr[1:0]};

  always_comb begin
    state_next = state;
    pend_next  = flush_pend;
    case (state)
      IDLE: begin
        if (flush_go)        state_next = FLUSH;
        else if (cpu.req) begin
          if (cpu.we)        state_next = WR_THRU;
          else if (req_hit)  state_next = RESP;
          else               state_next = RD_MISS;
        end
      end
      RD_MISS, WR_THRU: if (mem.rdy) state_next = RESP;
      RESP:                          state_next = IDLE;
      FLUSH: begin
        if (&flush_idx) begin
          state_next = IDLE;
          pend_next  = 1'b0;
        end
      end
      default:                       state_next = IDLE;
    endcase
    // Flushes arriving mid-transaction are remembered; during FLUSH they are
    // absorbed because the running sweep already covers them.
    if (flush && state != IDLE && state != FLUSH) pend_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_valid <= '0;
      flush_pend <= 1'b0;
      flush_busy <= 1'b0;
      flush_idx  <= '0;
      cpu.rdy    <= 1'b0;
      cpu.rdata  <= '0;
      mem.req    <= 1'b0;
      mem.we     <= 1'b0;
      mem.addr   <= '0;
      mem.wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_next;
      flush_pend <= pend_next;
      flush_busy <= pend_next | (state_next == FLUSH);
      cpu.rdy    <= (state_next == RESP);
      case (state)
        IDLE: begin
          flush_idx <= '0;
          if (accept) begin
            if (!cpu.we && req_hit) begin
              cpu.rdata <= line_data[req_idx];
              hit_cnt   <= hit_cnt + 32'd1;
            end else begin
              mem.req   <= 1'b1;
              mem.we    <= cpu.we;
              mem.addr  <= {cpu.addr[31:2], 2'b00};
              mem.wdata <= cpu.wdata;
              if (!cpu.we && req_cached) miss_cnt <= miss_cnt + 32'd1;
            end
          end
        end
        RD_MISS: begin
          if (mem.rdy) begin
            cpu.rdata <= mem.rdata;
            mem.req   <= 1'b0;
            if (fill_cached) line_valid[fill_idx] <= 1'b1;
          end
        end
        WR_THRU: begin
          if (mem.rdy) begin
            mem.req <= 1'b0;
            mem.we  <= 1'b0;
          end
        end
        FLUSH: begin
          line_valid[flush_idx] <= 1'b0;
          flush_idx             <= flush_idx + IDX_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Line data and tags are never reset; validity alone decides a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept && cpu.we && req_hit) line_data[req_idx] <= cpu.wdata;
      if (state == RD_MISS && mem.rdy && fill_cached) begin
        line_data[fill_idx] <= mem.rdata;
        line_tag[fill_idx]  <= fill_tag;
      end
    end
  end
endmodule

// File: tb/tb_limn2600_cache.sv
// tb_limn2600_cache: drives directed and random CPU traffic into
// limn2600_cache against a behavioural DRAM with random response delay, and
// checks every response against a reference model of lines and counters.
module tb_limn2600_cache;
  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        flush_busy;
  logic [31:0] hit_cnt, miss_cnt;
  logic [2:0]  dbg_state;

  limn2600_cache_if cpu_bus ();
  limn2600_cache_if mem_bus ();

  limn2600_cache #(.IDX_BITS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .flush      (flush),
    .flush_busy (flush_busy),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  bit          m_valid [LINES];
  logic [23:0] m_tag   [LINES];
  logic [31:0] exp_hit, exp_miss;
  logic [31:0] dram [logic [31:0]];
  bit          dram_hold;
  int          wait_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dram_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (dram.exists(w)) return dram[w];
    return w ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    exp_hit  = '0;
    exp_miss = '0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // ---------------- DRAM responder ----------------
  // Decides just after each rising edge; rdy is then sampled by the cache on
  // the following edge.
  initial begin
    mem_bus.rdy   = 1'b0;
    mem_bus.rdata = '0;
    wait_cnt      = -1;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mem_bus.req) begin
        mem_bus.rdy = 1'b0;
        wait_cnt    = -1;
      end else if (!mem_bus.rdy) begin
        if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
        if (wait_cnt == 0 && !dram_hold) begin
          mem_bus.rdy = 1'b1;
          if (mem_bus.we) dram[mem_bus.addr] = mem_bus.wdata;
          else            mem_bus.rdata = dram_rd(mem_bus.addr);
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- driver: one CPU transaction ----------------
  // Called right after a falling edge; returns right after a falling edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic        cached, hit, saw_mem, done;
    logic [5:0]  idx;
    logic [23:0] tg;
    logic [31:0] wa, exp_v;
    int          cyc, rdy_cyc;
    wa     = {addr[31:2], 2'b00};
    cached = !addr[31];
    idx    = addr[7:2];
    tg     = addr[31:8];
    hit    = cached && m_valid[idx] && (m_tag[idx] == tg);
    exp_v  = '0;
    if (!we) exp_q.push_back(dram_rd(addr));
    cpu_bus.req   = 1'b1;
    cpu_bus.we    = we;
    cpu_bus.addr  = addr;
    cpu_bus.wdata = wd;
    cyc = 0; rdy_cyc = -1; saw_mem = 1'b0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_bus.req && !saw_mem) begin
        saw_mem = 1'b1;
        check("mem_addr", mem_bus.addr, wa);
        check("mem_we", 32'(mem_bus.we), 32'(we));
        if (we) check("mem_wdata", mem_bus.wdata, wd);
      end
      if (cpu_bus.rdy)      done = 1'b1;
      else if (mem_bus.rdy) rdy_cyc = cyc;
    end
    cpu_bus.req = 1'b0;
    check("resp_seen", 32'(done), 32'd1);
    if (!we) exp_v = exp_q.pop_front();
    if (done) begin
      check("mem_issued", 32'(saw_mem), 32'(!(hit && !we)));
      if (hit && !we) check("hit_latency", cyc, 1);
      else            check("mem_to_rdy", cyc - rdy_cyc, 1);
      if (!we) check("rdata", cpu_bus.rdata, exp_v);
    end
    if (cached && !we) begin
      if (hit) exp_hit++;
      else begin
        exp_miss++;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
    end
    check("hit_cnt", hit_cnt, exp_hit);
    check("miss_cnt", miss_cnt, exp_miss);
    @(negedge clk);
    check("rdy_pulse", 32'(cpu_bus.rdy), 32'd0);
    if (!we && done) check("rdata_hold", cpu_bus.rdata, exp_v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, bad;
    logic [31:0] a, v;
    rst = 1'b1; flush = 1'b0; dram_hold = 1'b0;
    cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
    dram[32'h0000_0100] = 32'hDEAD_BEEF;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_rdy", 32'(cpu_bus.rdy), 32'd0);
    check("rst_cpu_rdata", cpu_bus.rdata, 32'd0);
    check("rst_mem_req", 32'(mem_bus.req), 32'd0);
    check("rst_mem_we", 32'(mem_bus.we), 32'd0);
    check("rst_mem_addr", mem_bus.addr, 32'd0);
    check("rst_mem_wdata", mem_bus.wdata, 32'd0);
    check("rst_flush_busy", 32'(flush_busy), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, hit, conflicting tag on the same index, re-miss.
    access(1'b0, 32'h0000_0100, '0);
    check("cold_rdata", cpu_bus.rdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0100, '0);
    check("hit_one", hit_cnt, 32'd1);
    access(1'b0, 32'h0000_0200, '0);
    access(1'b0, 32'h0000_0100, '0);
    check("miss_three", miss_cnt, 32'd3);

    // Write hit updates the line; write miss does not allocate.
    access(1'b1, 32'h0000_0100, 32'h1234_5678);
    access(1'b0, 32'h0000_0100, '0);
    check("wr_hit_rdata", cpu_bus.rdata, 32'h1234_5678);
    access(1'b1, 32'h0000_0300, 32'hCAFE_0300);
    access(1'b0, 32'h0000_0300, '0);

    // Uncached bypass: always goes to DRAM, never counted, never filled.
    access(1'b0, 32'h8000_0010, '0);
    access(1'b0, 32'h8000_0010, '0);
    access(1'b0, 32'h0000_0010, '0);

    // Flush arriving during an outstanding miss.
    access(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0204, '0);
    access(1'b0, 32'h0000_0408, '0);
    dram_hold = 1'b1;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 32'h0000_050C;
    n = 0;
    while (!mem_bus.req && n < 20) begin @(negedge clk); n++; end
    check("fl_miss_req", 32'(mem_bus.req), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy_set", 32'(flush_busy), 32'd1);
    dram_hold = 1'b0;
    n = 0;
    while (!cpu_bus.rdy && n < 50) begin @(negedge clk); n++; end
    check("fl_miss_rdy", 32'(cpu_bus.rdy), 32'd1);
    check("fl_miss_rdata", cpu_bus.rdata, dram_rd(32'h0000_050C));
    exp_miss++;
    check("fl_miss_cnt", miss_cnt, exp_miss);
    // Hold a new read through the whole flush; it must not be taken.
    cpu_bus.addr = 32'h0000_0100;
    n = 0; bad = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!flush_busy) break;
      n++;
      if (cpu_bus.rdy || mem_bus.req) bad++;
    end
    cpu_bus.req = 1'b0;
    check("fl_len_pending", n, LINES + 1);
    check("fl_stall", bad, 0);
    model_flush();
    access(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0204, '0);
    access(1'b0, 32'h0000_0408, '0);

    // Flush from IDLE, with an extra pulse absorbed mid-sweep.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (flush_busy && n < 200) begin
      n++;
      flush = (n == 10);
      @(negedge clk);
    end
    flush = 1'b0;
    check("fl_len_idle", n, LINES);
    model_flush();

    // Randomized traffic over a few indices and tags to force conflicts.
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      v = $urandom;
      access($urandom_range(0, 2) == 0, a, v);
    end

    // Reset while a miss is outstanding.
    access(1'b0, 32'h0000_0100, '0);
    dram_hold = 1'b1;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 32'h0000_0604;
    n = 0;
    while (!mem_bus.req && n < 20) begin @(negedge clk); n++; end
    check("rst_miss_req", 32'(mem_bus.req), 32'd1);
    rst = 1'b1;
    cpu_bus.req = 1'b0;
    @(negedge clk);
    check("mrst_mem_req", 32'(mem_bus.req), 32'd0);
    check("mrst_cpu_rdy", 32'(cpu_bus.rdy), 32'd0);
    check("mrst_hit_cnt", hit_cnt, 32'd0);
    check("mrst_miss_cnt", miss_cnt, 32'd0);
    check("mrst_busy", 32'(flush_busy), 32'd0);
    rst = 1'b0;
    dram_hold = 1'b0;
    model_reset();
    @(negedge clk);
    access(1'b0, 32'h0000_0100, '0);
    check("post_rst_miss", miss_cnt, 32'd1);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
